// File: rtl/df_collect_o_pkg.sv
// Shared constants and FSM encoding for the hidden-layer result collector.
// The bias slot (0xf) lives in the consumer's mux and is never stored here.
package df_collect_o_pkg;

  localparam int DF_DATA_WIDTH = 16;
  localparam int DF_NUM_IN     = 15;
  localparam int DF_ADDR_WIDTH = 4;

  localparam logic [15:0] BIAS_ONE = 16'h1000;  // 1.0 in Q4.12

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/df_slot_reg.sv
// One storage slot of the collector bank: synchronous reset, clear and
// write-enable. Clear wins over write.
module df_slot_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // NOTE: every slot is reset explicitly; a mid-frame reset must leave the
  // consumer-visible bank all zero, not merely the pointer.
  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else if (we)      q <= d;
  end

endmodule

// File: rtl/df_collect_o.sv
// Collects a serial valid/ready word stream into NUM_IN slots and holds the
// bank as a frame until the consumer acknowledges it.
module df_collect_o #(
  parameter int DATA_WIDTH = df_collect_o_pkg::DF_DATA_WIDTH,
  parameter int NUM_IN     = df_collect_o_pkg::DF_NUM_IN,
  parameter int ADDR_WIDTH = df_collect_o_pkg::DF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         frame_valid,
  input  logic                         frame_ack,
  output logic [NUM_IN*DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0]        wr_cnt,
  output logic                         short_frame
);
  import df_collect_o_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(NUM_IN - 1);
  localparam logic [ADDR_WIDTH-1:0] SAT_CNT   = ADDR_WIDTH'(NUM_IN);

  state_t state, state_nx;
  logic   xfer;
  logic   frame_done;

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    in_ready    = 1'b0;
    frame_valid = 1'b0;
    state_nx    = state;
    case (state)
      FILL: begin
        in_ready = !reset;
      end
      FULL: begin
        frame_valid = 1'b1;
        if (frame_ack) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
    xfer       = in_valid && in_ready;
    frame_done = xfer && (in_last || (wr_cnt == LAST_SLOT));
    if (frame_done) state_nx = FULL;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      wr_cnt      <= '0;
      short_frame <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FULL && frame_ack)
        wr_cnt <= '0;
      else if (xfer && wr_cnt != SAT_CNT)
        wr_cnt <= wr_cnt + 1'b1;
      // An early in_last leaves the tail slots zeroed; flag it until reset.
      if (xfer && in_last && wr_cnt != LAST_SLOT)
        short_frame <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_IN; k++) begin : g_slot
    logic slot_we;
    logic slot_clr;

    assign slot_we  = xfer && (wr_cnt == ADDR_WIDTH'(k));
    assign slot_clr = xfer && in_last && (wr_cnt < ADDR_WIDTH'(k));

    df_slot_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .we    (slot_we),
      .clr   (slot_clr),
      .d     (in_data),
      .q     (data_out[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
